// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver with a two-register Wishbone slave (DATA, STATUS).
// Optional level interrupt enabled by defining RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
  parameter int BITS      = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int IRQ_LEVEL = 1
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst_n,
  input  logic            i_rx_done,
  input  logic [BITS-1:0] i_rx_data,
  input  logic            i_wb_cyc,
  input  logic            i_wb_we,
  input  logic            i_wb_adr,
  input  logic [31:0]     i_wb_dat,
  output logic [31:0]     o_wb_rdt,
  output logic            o_wb_ack,
  output logic            o_irq
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_next;
  logic            overrun, overrun_next, done_q;
  logic            access, push_req, push, pop, empty, full, ovr_clr;
  logic [31:0]     rd_data;

  always_comb begin
    access       = i_wb_cyc & ~o_wb_ack;
    push_req     = i_rx_done & ~done_q;
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    pop          = access & ~i_wb_we & ~i_wb_adr & ~empty;
    // a pop in the same edge frees a slot, so a push into a full FIFO is still accepted
    push         = push_req & (~full | pop);
    ovr_clr      = access & i_wb_we & i_wb_adr & i_wb_dat[2];
    overrun_next = (push_req & full & ~pop) | (overrun & ~ovr_clr);
    count_next   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_comb begin
    rd_data = '0;
    if (i_wb_adr) begin
      rd_data[0]        = empty;
      rd_data[1]        = full;
      rd_data[2]        = overrun;
      rd_data[3]        = o_irq;
      rd_data[8 +: AW+1] = count;
    end else if (!empty) begin
      rd_data[BITS]          = 1'b1;
      rd_data[BITS-1:0]      = mem[rd_ptr];
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      done_q   <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      done_q   <= i_rx_done;
      o_wb_ack <= access;
      count    <= count_next;
      overrun  <= overrun_next;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (access && !i_wb_we) o_wb_rdt <= rd_data;
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst_n && push) mem[wr_ptr] <= i_rx_data;
  end

`ifdef RX_FIFO_IRQ_EN
  localparam logic [AW:0] IRQ_THR = IRQ_LEVEL[AW:0];

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) o_irq <= 1'b0;
    else             o_irq <= (count_next >= IRQ_THR) | overrun_next;
  end

  logic unused_bits;
  assign unused_bits = ^{i_wb_dat[31:3], i_wb_dat[1:0]};
`else
  assign o_irq = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{i_wb_dat[31:3], i_wb_dat[1:0], IRQ_LEVEL[0]};
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus hand-written corner sequences.
module tb_uart_rx_fifo;

`ifdef RX_FIFO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic        adr = 1'b0;
  logic [31:0] dat = '0;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.BITS(8), .DEPTH(16), .AW(4), .IRQ_LEVEL(4)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_adr(adr), .i_wb_dat(dat),
    .o_wb_rdt(rdt), .o_wb_ack(ack), .o_irq(irq)
  );

  typedef enum logic [1:0] {OP_PUSH, OP_RD, OP_WR} op_e;
  typedef struct {
    op_e         op;
    logic        adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(op_e op, logic a, logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.op = op; v.adr = a; v.dat = d; v.exp = e;
    return v;
  endfunction

  // STATUS expectation with the interrupt bit folded in (threshold 4 or overrun)
  function automatic logic [31:0] st(logic [31:0] e);
    logic [31:0] r;
    r = e;
    if (IRQ_EN && ((e[15:8] >= 8'd4) || e[2])) r[3] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1; rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wb(input logic w, input logic a, input logic [31:0] d, output logic [31:0] r);
    int n;
    @(negedge clk);
    cyc = 1'b1; we = w; adr = a; dat = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got ack=0 expected ack=1 within 8 cycles");
    end
    r = rdt;
    cyc = 1'b0; we = 1'b0; dat = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ack", {31'b0, ack}, 32'h0);
    check("reset_rdt", rdt, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;

    vecs.push_back(mk(OP_RD, 1'b1, 0, st(32'h0000_0001)));
    vecs.push_back(mk(OP_PUSH, 1'b0, 32'hA5, 0));
    vecs.push_back(mk(OP_PUSH, 1'b0, 32'h3C, 0));
    vecs.push_back(mk(OP_RD, 1'b1, 0, st(32'h0000_0200)));
    vecs.push_back(mk(OP_RD, 1'b0, 0, 32'h0000_01A5));
    vecs.push_back(mk(OP_RD, 1'b0, 0, 32'h0000_013C));
    vecs.push_back(mk(OP_RD, 1'b1, 0, st(32'h0000_0001)));
    vecs.push_back(mk(OP_RD, 1'b0, 0, 32'h0000_0000));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(OP_PUSH, 1'b0, i, 0));
    vecs.push_back(mk(OP_PUSH, 1'b0, 32'hFF, 0));
    vecs.push_back(mk(OP_RD, 1'b1, 0, st(32'h0000_1006)));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(OP_RD, 1'b0, 0, 32'h100 + i));
    vecs.push_back(mk(OP_RD, 1'b0, 0, 32'h0000_0000));
    vecs.push_back(mk(OP_RD, 1'b1, 0, st(32'h0000_0005)));
    vecs.push_back(mk(OP_WR, 1'b0, 32'h4, 0));
    vecs.push_back(mk(OP_RD, 1'b1, 0, st(32'h0000_0005)));
    vecs.push_back(mk(OP_WR, 1'b1, 32'h4, 0));
    vecs.push_back(mk(OP_RD, 1'b1, 0, st(32'h0000_0001)));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_PUSH: push(vecs[i].dat[7:0]);
        OP_WR:   wb(1'b1, vecs[i].adr, vecs[i].dat, r);
        default: begin
          wb(1'b0, vecs[i].adr, 0, r);
          check($sformatf("vec%0d", i), r, vecs[i].exp);
        end
      endcase
    end
    check("irq_after_clear", {31'b0, irq}, 32'h0);

    // full FIFO: pop and push land on the same edge
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    check("irq_full", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; adr = 1'b0; rx_done = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    check("coinc_ack", {31'b0, ack}, 32'h1);
    check("coinc_rdt", rdt, 32'h0000_0120);
    cyc = 1'b0; rx_done = 1'b0;
    wb(1'b0, 1'b1, 0, r);
    check("coinc_status", r, st(32'h0000_1002));
    for (int i = 1; i < 16; i++) begin
      wb(1'b0, 1'b0, 0, r);
      check($sformatf("coinc_drain%0d", i), r, 32'h120 + i);
    end
    wb(1'b0, 1'b0, 0, r);
    check("coinc_last", r, 32'h0000_0155);

    // empty FIFO: read returns 0 while the simultaneous push is kept
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; adr = 1'b0; rx_done = 1'b1; rx_data = 8'h9B;
    @(negedge clk);
    check("empty_coinc_rdt", rdt, 32'h0);
    cyc = 1'b0; rx_done = 1'b0;
    wb(1'b0, 1'b1, 0, r);
    check("empty_coinc_status", r, st(32'h0000_0100));
    wb(1'b0, 1'b0, 0, r);
    check("empty_coinc_data", r, 32'h0000_019B);

    // pointer wrap
    for (int i = 0; i < 40; i++) begin
      b = 8'(8'h40 + i);
      push(b);
      wb(1'b0, 1'b0, 0, r);
      check($sformatf("wrap%0d", i), r, {23'b0, 1'b1, b});
    end

    // interrupt threshold at 4 entries
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
    check("irq_at3", {31'b0, irq}, 32'h0);
    push(8'h73);
    check("irq_at4", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
    wb(1'b0, 1'b0, 0, r);
    check("irq_pop_data", r, 32'h0000_0170);
    check("irq_after_pop", {31'b0, irq}, 32'h0);

    // reset with data pending clears count and read data
    push(8'hEE);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset2_rdt", rdt, 32'h0);
    check("reset2_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    wb(1'b0, 1'b1, 0, r);
    check("reset2_status", r, st(32'h0000_0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
